// File: rtl/inst_q_param.sv
// In-order instruction queue between fetch and issue.
// Circular buffer with a single-cycle flush, occupancy count, almost-full
// threshold and a look-ahead read port exposing the head+1 entry.
module inst_q_param #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq,
    input  logic [WIDTH-1:0]           enq_data,
    output logic                       enq_ready,
    input  logic                       deq,
    output logic                       deq_valid,
    output logic [WIDTH-1:0]           deq_data,
    output logic                       peek_valid,
    output logic [WIDTH-1:0]           peek_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [CW-1:0] AfC    = CW'(AF_THRESH);
    localparam logic [CW-1:0] TwoC   = CW'(2);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic enq_acc;
    logic deq_acc;
    logic [PW-1:0] head_nxt;

    // Flags are pure functions of the registered occupancy.
    always_comb begin
        full        = (count_q == DepthC);
        empty       = (count_q == '0);
        almost_full = (count_q >= AfC);
        peek_valid  = (count_q >= TwoC);
        deq_valid   = !empty;
        count       = count_q;
    end

    // Handshake: a full queue still accepts when the head leaves in the same cycle.
    always_comb begin
        enq_ready = !flush && (!full || (deq && !empty));
        enq_acc   = enq && enq_ready;
        deq_acc   = !flush && deq && !empty;
    end

    // Combinational reads at head and head+1; zero when the slot is not occupied.
    always_comb begin
        head_nxt  = head_q + PW'(1);
        deq_data  = empty ? '0 : mem[head_q];
        peek_data = peek_valid ? mem[head_nxt] : '0;
    end

    // Next-state for pointers and count; flush clears everything.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_acc) begin
                tail_d = tail_q + PW'(1);
            end
            if (deq_acc) begin
                head_d = head_nxt;
            end
            count_d = count_q + CW'(enq_acc) - CW'(deq_acc);
        end
    end

    // Pointer and count registers; rst outranks flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage write at tail; contents are left alone by reset and flush.
    always_ff @(posedge clk) begin
        if (!rst && enq_acc) begin
            mem[tail_q] <= enq_data;
        end
    end

endmodule

// File: tb/tb_inst_q_param.sv
// Self-checking bench for inst_q_param (WIDTH=32, DEPTH=4, AF_THRESH=3).
// Reference model is a plain queue of entries.
module tb_inst_q_param;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 4;
    localparam int unsigned AF = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          enq;
    logic [W-1:0]  enq_data;
    logic          enq_ready;
    logic          deq;
    logic          deq_valid;
    logic [W-1:0]  deq_data;
    logic          peek_valid;
    logic [W-1:0]  peek_data;
    logic [2:0]    count;
    logic          full;
    logic          empty;
    logic          almost_full;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] q[$];

    inst_q_param #(
        .WIDTH(W),
        .DEPTH(D),
        .AF_THRESH(AF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .enq(enq),
        .enq_data(enq_data),
        .enq_ready(enq_ready),
        .deq(deq),
        .deq_valid(deq_valid),
        .deq_data(deq_data),
        .peek_valid(peek_valid),
        .peek_data(peek_data),
        .count(count),
        .full(full),
        .empty(empty),
        .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model for the inputs currently applied.
    task automatic check_all();
        int n;
        logic exp_rdy;
        n = q.size();
        exp_rdy = !flush && ((n < D) || (deq && n > 0));
        chk("count", W'(count), W'(n));
        chk("empty", W'(empty), W'(n == 0));
        chk("full", W'(full), W'(n == D));
        chk("almost_full", W'(almost_full), W'(n >= AF));
        chk("deq_valid", W'(deq_valid), W'(n > 0));
        chk("peek_valid", W'(peek_valid), W'(n >= 2));
        chk("deq_data", deq_data, (n > 0) ? q[0] : '0);
        chk("peek_data", peek_data, (n >= 2) ? q[1] : '0);
        chk("enq_ready", W'(enq_ready), W'(exp_rdy));
    endtask

    // One cycle: apply inputs after the falling edge, check, clock, update model.
    task automatic step(input logic fl, input logic en, input logic [W-1:0] d, input logic dq);
        logic ea;
        logic da;
        int n;
        flush    = fl;
        enq      = en;
        enq_data = d;
        deq      = dq;
        #1;
        check_all();
        n  = q.size();
        ea = !fl && en && ((n < D) || (dq && n > 0));
        da = !fl && dq && (n > 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (da) void'(q.pop_front());
            if (ea) q.push_back(d);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        enq = 1'b0;
        enq_data = '0;
        deq = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset then idle.
        step(1'b0, 1'b0, '0, 1'b0);

        // Fill with A0..A3.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'hA0 + W'(i), 1'b0);
        chk("full_after_fill", W'(full), W'(1));
        chk("head_after_fill", deq_data, 32'hA0);

        // Enqueue and dequeue together while full.
        step(1'b0, 1'b1, 32'hB0, 1'b1);
        chk("head_after_simul", deq_data, 32'hA1);
        chk("count_after_simul", W'(count), W'(4));

        // Drain, then one extra deq on empty.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1);
        chk("empty_after_drain", W'(empty), W'(1));

        // Enqueue and dequeue together while empty.
        step(1'b0, 1'b1, 32'hC0, 1'b1);
        chk("head_c0", deq_data, 32'hC0);

        // Bring count to 3, then flush alongside an enqueue.
        step(1'b0, 1'b1, 32'hC1, 1'b0);
        step(1'b0, 1'b1, 32'hC2, 1'b0);
        step(1'b1, 1'b1, 32'hD0, 1'b0);
        chk("count_after_flush", W'(count), W'(0));
        chk("deq_data_after_flush", deq_data, '0);
        step(1'b0, 1'b0, '0, 1'b0);

        // Randomised traffic with occasional flush and mid-burst reset.
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 50) == 0) begin
                rst = 1'b1;
                enq = 1'b1;
                enq_data = $urandom;
                deq = 1'b1;
                @(posedge clk);
                q.delete();
                @(negedge clk);
                rst = 1'b0;
            end
            step(($urandom % 25) == 0, ($urandom % 3) != 0, $urandom, ($urandom % 2) == 0);
        end
        step(1'b0, 1'b0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_q_param.md
# inst_q_param

Parametrised in-order instruction queue: a circular buffer of DEPTH entries, each WIDTH bits, between fetch and the issue stage. Fetch enqueues at the tail; issue dequeues at the head. The block adds four things over a fixed queue:
- a one-cycle flush for branch mispredict and exception recovery;
- an occupancy count and an almost-full threshold, so fetch can throttle early;
- a second read port exposing the head+1 entry for dual-issue look-ahead;
- explicit ready/valid handshakes alongside full/empty.

## Interface
Parameters:
- WIDTH, 32: bits per entry.
- DEPTH, 8: number of entries. Must be a power of two, ≥ 2.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH. Legal range 1..DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all entries; highest priority.
- enq  input  1  enqueue request from fetch.
- enq_data  input  WIDTH  entry to write at tail.
- enq_ready  output  1  enqueue accepted this cycle if enq is high. Equals !full || (deq && !empty), forced 0 while flush.
- deq  input  1  dequeue request from issue.
- deq_valid  output  1  head entry present (= !empty).
- deq_data  output  WIDTH  entry at head; 0 when empty.
- peek_valid  output  1  count ≥ 2.
- peek_data  output  WIDTH  entry at head+1 (mod DEPTH); 0 when !peek_valid.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count ≥ AF_THRESH.

## Operation
- State:
  - head and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH;
  - count register;
  - storage array of DEPTH × WIDTH bits.
  - All flags derive combinationally from count.
- Accept rules, evaluated each cycle with flush low:
  - enq_acc = enq && enq_ready.
  - deq_acc = deq && !empty.
- Updates on enq_acc:
  - mem[tail] ← enq_data.
  - tail ← tail+1.
- Updates on deq_acc:
  - head ← head+1.
- count ← count + enq_acc − deq_acc.
- Simultaneous enq and deq:
  - Full: both accepted; count stays DEPTH. The freed head slot is the new tail slot.
  - Empty: only enq is accepted (no bypass); count becomes 1.
  - Otherwise: both accepted; count unchanged.
- deq while empty is ignored: no pointer or count change, no error.
- enq while full without deq is rejected: enq_ready is 0, storage is untouched, and fetch must hold the request.
- Flush:
  - When flush is high, head, tail and count all become 0 on the next edge.
  - enq and deq in the same cycle are ignored, and enq_ready is 0 that cycle.
  - Storage contents are don't-care after flush.
- Reset has the same effect as flush, plus all outputs are driven to their reset values. rst has priority over flush.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no extra state. full and empty are distinguished only by count.

## Timing
- Reset values, in the cycle after rst is sampled high:
  - count = 0, empty = 1, deq_valid = 0, full = 0, almost_full = 0 (AF_THRESH ≥ 1);
  - peek_valid = 0, deq_data = 0, peek_data = 0, enq_ready = 1.
- Enqueue-to-visibility latency is 1 cycle. Data written at edge N appears on deq_data (if at head) or peek_data (if at head+1) after edge N.
- deq_data and peek_data are combinational reads of storage, indexed by the registered head. No read latency.
- After a deq_acc at edge N, deq_data shows the former head+1 entry after edge N.
- enq_ready is combinational from full, deq and flush. It has no combinational path from enq.
- The flags (full, empty, almost_full, peek_valid, deq_valid) change only on clock edges, except through their dependence on count.
- Reset or flush in the middle of a burst: any transfer presented in that cycle is lost, and the queue is empty in the next cycle.

## Test plan
Configuration: WIDTH=32, DEPTH=4, AF_THRESH=3.
- Reset, then idle:
  - count=0, empty=1, enq_ready=1, deq_data=0, peek_valid=0.
- Enqueue 0xA0..0xA3 on 4 consecutive cycles:
  - count goes 1,2,3,4; almost_full rises with count=3; full=1 at the end; enq_ready=0.
  - deq_data=0xA0, peek_data=0xA1.
- While full, assert enq=0xB0 and deq together:
  - Both accepted; count stays 4.
  - deq_data=0xA1; the entry 0xB0 occupies the wrapped slot 0.
- Then dequeue 4 times:
  - deq_data sequence 0xA1, 0xA2, 0xA3, 0xB0; empty=1 at the end.
  - A further deq leaves count=0.
- Enqueue 0xC0 and deq in the same cycle while empty:
  - count=1, deq_data=0xC0 the next cycle.
- With count=3, assert flush together with enq=0xD0:
  - The next cycle has count=0, empty=1, deq_data=0.
  - 0xD0 is never observed on deq_data.
